// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory write port
//
// Receives a big-endian byte stream over a valid/ready handshake, packs four
// bytes into one 32-bit instruction word and writes it to consecutive word
// addresses starting at 0. `busy` stays high for the whole load so the core
// can be held idle until the image is in place.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined     -> `checksum` accumulates the sum (mod 2^32) of written words
//   not defined -> no accumulator, `checksum` tied to 0
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start, load_len load request and word count (sampled only in IDLE)
//   byte_in         stream data byte
//   byte_valid      stream byte valid
//   byte_ready      loader accepts a byte this cycle (RECV state)
//   mem_we          instruction memory write enable (registered)
//   mem_addr        word address of the write, zero-extended (registered)
//   mem_wdata       assembled instruction word (registered)
//   busy            load in progress (RECV or WRITE)
//   done            one-cycle pulse at load completion
//   error           sticky: last start had load_len > DEPTH
//   checksum        running sum of written words (0 when feature disabled)

module imem_loader #(
   parameter int DEPTH = 1025,
   parameter int LEN_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] load_len,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      checksum
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0] left_q, left_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [23:0]      shift_q, shift_d;   // first three bytes of the word in flight
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             error_q, error_d;

   logic             start_ok;           // start in IDLE with a legal length

   assign start_ok = (state_q == S_IDLE) && start && (load_len <= DEPTH_L);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      left_d      = left_q;
      bcnt_d      = bcnt_q;
      shift_d     = shift_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      error_d     = error_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (load_len > DEPTH_L) begin
                  error_d = 1'b1;
               end else begin
                  error_d = 1'b0;
                  if (load_len == '0) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d  = '0;
                     left_d  = load_len;
                     bcnt_d  = 2'd0;
                     state_d = S_RECV;
                  end
               end
            end
         end

         S_RECV: begin
            if (byte_valid) begin
               if (bcnt_q == 2'd3) begin
                  // Fourth byte completes the word: present it to memory next cycle.
                  mem_wdata_d = {shift_q, byte_in};
                  mem_addr_d  = 32'(addr_q);
                  mem_we_d    = 1'b1;
                  bcnt_d      = 2'd0;
                  state_d     = S_WRITE;
               end else begin
                  shift_d = {shift_q[15:0], byte_in};
                  bcnt_d  = bcnt_q + 2'd1;
               end
            end
         end

         S_WRITE: begin
            addr_d = addr_q + 1'b1;
            left_d = left_q - 1'b1;
            bcnt_d = 2'd0;
            if (left_q == LEN_W'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RECV;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         left_q      <= '0;
         bcnt_q      <= 2'd0;
         shift_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         left_q      <= left_d;
         bcnt_q      <= bcnt_d;
         shift_q     <= shift_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         error_q     <= error_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   // The word being written is already in mem_wdata_q during WRITE.
   always_comb begin
      checksum_d = checksum_q;
      if (start_ok) begin
         checksum_d = '0;
      end else if (state_q == S_WRITE) begin
         checksum_d = checksum_q + mem_wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
   assign checksum        = 32'd0;
`endif

   // State-decoded outputs come straight from the state register.
   assign byte_ready = (state_q == S_RECV);
   assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign error      = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory write port at consecutive word addresses. It is the write-side counterpart of the synchronous instruction fetch port. It holds `busy` high while loading so the core can be kept idle until the program image is in place.

## Interface

- `DEPTH`, 1025: number of word locations in instruction memory (word-indexed, addresses 0..DEPTH-1).
- `LEN_W`, 11: width of the word-count input; must satisfy 2^LEN_W > DEPTH.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a load; sampled only in IDLE.
- `load_len`  input  LEN_W  number of words to load; sampled with `start`.
- `byte_in`  input  8  stream data byte.
- `byte_valid`  input  1  `byte_in` is valid.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  instruction memory write enable (registered).
- `mem_addr`  output  32  word address of the write (registered, zero-extended).
- `mem_wdata`  output  32  assembled instruction word (registered).
- `busy`  output  1  load in progress (RECV or WRITE).
- `done`  output  1  one-cycle pulse at load completion.
- `error`  output  1  sticky: last `start` had `load_len` > DEPTH.
- `checksum`  output  32  running sum of written words (see Configuration).

## Operation

- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: `byte_ready`=0. On `start`:
  - `load_len` > DEPTH -> `error`=1, remain IDLE, no writes.
  - `load_len` == 0 -> `error`=0, go DONE.
  - otherwise -> `error`=0, word address counter=0, words_left=`load_len`, byte count=0, checksum=0, go RECV.
- RECV: `byte_ready`=1. A byte is accepted on an edge where `byte_valid` && `byte_ready`. Byte order big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0]. On acceptance of the 4th byte: load `mem_wdata`, `mem_addr`=current address, set `mem_we`, go WRITE.
- WRITE: `byte_ready`=0, `mem_we`=1 for exactly this cycle. At the end of the cycle: address+1, words_left-1, byte count=0; words_left becomes 0 -> DONE, else -> RECV.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `load_len` changes after the `start` cycle have no effect.
- `byte_valid` low in RECV stalls indefinitely; no timeout.
- Address never exceeds DEPTH-1 because of the length check; no wrap-around.
- `error` clears only on the next accepted `start` with a legal length, or on reset.

## Timing

- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `checksum`=0, state IDLE.
- `rst` mid-load: the next cycle is IDLE with every output at its reset value. A partially assembled word is discarded and not written.
- `start` at edge E -> RECV (`busy`=1, `byte_ready`=1) in cycle E+1.
- 4th byte accepted at edge N -> `mem_we`=1 in cycle N+1 -> RECV again in cycle N+2.
- Throughput: at most one word per 5 cycles with back-to-back bytes.
- Last WRITE in cycle W -> `done`=1 in cycle W+1, `busy`=0 in W+1, IDLE in W+2.
- `load_len`=0: `start` at E -> `done` in E+1, no `mem_we`.

## Configuration

- `IMEM_LOADER_CHECKSUM_EN` defined: `checksum` is cleared on an accepted `start` and updated with `checksum` + `mem_wdata` (mod 2^32) in each WRITE cycle. The value is valid from the cycle `done` asserts and holds until the next accepted `start`.
- Not defined: no accumulator is synthesized and `checksum` is tied to 0. The port remains present.

## Test plan

- Reset, then `start` with `load_len`=2 and bytes 0x20,0x08,0x00,0x05,0x8C,0x09,0x00,0x04 with `byte_valid` always high -> writes 0x20080005 at address 0 and 0x8C090004 at address 1, `mem_we` high for 1 cycle each, `done` pulses 1 cycle after the 2nd write, checksum 0xAC110009 (with the macro defined).
- Same load with `byte_valid` toggling every other cycle -> identical writes and data; `byte_ready` low only in WRITE/IDLE/DONE.
- `start` with `load_len`=1026 -> `error`=1, `busy`=0, no `mem_we`. A following `start` with `load_len`=1 -> `error`=0, one write at address 0.
- `start` with `load_len`=0 -> `done` the next cycle, no writes, `error`=0.
- `rst` after 2 bytes of the 2nd word -> all outputs return to reset values next cycle, no write of the partial word. A fresh load then starts at address 0.
- `start` pulsed during RECV -> ignored; the address sequence and `load_len` are unchanged, and 1025-word load writes addresses 0..1024 then `done`.
